numa_rx_parser: RTL
===================

NUMA_RX_PARSER -- requirements
Module: numa_rx_parser

Interface
REQ-001 SHALL have parameter UdpPort, default 16'd3422, the UDP destination port that carries remote-memory write frames.
REQ-002 SHALL have parameter MaxLen, default 11'd1024, the largest accepted payload data length in bytes.
REQ-003 pcie_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 sys_rst_n  in  1  synchronous, active-low reset.
REQ-005 phy_dout  in  9  RX PHY FIFO word: [8]=frame-valid flag (0 marks the inter-frame gap), [7:0]=byte.
REQ-006 phy_empty  in  1  RX PHY FIFO empty.
REQ-007 phy_rd_en  out  1  RX PHY FIFO pop; phy_dout is valid the cycle after a pop with phy_empty low.
REQ-008 mst_din  out  18  master write-queue word: [17:16]=tag, [15:0]=payload.
REQ-009 mst_full  in  1  master write queue full.
REQ-010 mst_wr_en  out  1  master write-queue push.
REQ-011 if_macaddr  in  48  local MAC address.
REQ-012 if_v4addr  in  32  local IPv4 address.
REQ-013 pkt_cnt  out  16  count of accepted frames.
REQ-014 drop_cnt  out  16  count of filtered or aborted frames.

Function
REQ-015 Tags SHALL be: 2'b10 = address word, 2'b00 = data word, 2'b01 = last data word, 2'b11 = abort.
REQ-016 phy_rd_en SHALL equal !phy_empty & !mst_full & !mst_wr_en, and SHALL be 0 in state ADDR.
REQ-017 States SHALL be SYNC, IDLE, HDR, PARAM, ADDR, DATA and DROP.
REQ-018 SYNC SHALL discard bytes until a byte with [8]=0 is seen, then go to IDLE, so that a frame cut by reset is never parsed.
REQ-019 In IDLE, a byte with [8]=1 SHALL be frame byte 0; the byte counter SHALL be set to 1 and the state SHALL go to HDR.
REQ-020 HDR SHALL check bytes 0-5 equal if_macaddr or 48'hffffffffffff, and bytes 12-13 equal 16'h0800.
REQ-021 HDR SHALL check byte 14 equals 8'h45, byte 23 equals 8'h11, bytes 30-33 equal if_v4addr, and bytes 36-37 equal UdpPort.
REQ-022 All multi-byte fields SHALL be big-endian.
REQ-023 On any HDR mismatch, the state SHALL go to DROP and drop_cnt SHALL increment by 1.
REQ-024 After byte 41, the state SHALL go to PARAM.
REQ-025 PARAM SHALL latch bytes 42-45 as the 32-bit offset and bytes 46-47 as the 16-bit length.
REQ-026 If length is 0, odd, or greater than MaxLen, the state SHALL go to DROP and drop_cnt SHALL increment.
REQ-027 A valid length SHALL take the state to ADDR.
REQ-028 ADDR SHALL push {2'b10, offset[31:16]} and then {2'b10, offset[15:0]} on successive non-full cycles, then go to DATA.
REQ-029 DATA SHALL pair bytes high-first and push one 18-bit word per pair.
REQ-030 The final pair (length/2 words total) SHALL carry tag 01; pkt_cnt SHALL then increment and the state SHALL go to DROP to drain the remainder and FCS.
REQ-031 If a byte with [8]=0 arrives in HDR or PARAM (truncation), the state SHALL go to IDLE and drop_cnt SHALL increment.
REQ-032 If a byte with [8]=0 arrives in DATA, the block SHALL push {2'b11, 16'h0000} when not full, increment drop_cnt, and go to IDLE.
REQ-033 DROP SHALL pop until a byte with [8]=0, then go to IDLE.
REQ-034 The byte counter SHALL be 11 bits and saturate at 2047; frames longer than that SHALL still be drained correctly.
REQ-035 Counters SHALL wrap modulo 2^16.
REQ-036 mst_wr_en SHALL never assert while mst_full is 1, and SHALL assert at most once per cycle.

Reset
REQ-037 While sys_rst_n=0 at a clock edge, the following SHALL hold the next cycle: state=SYNC, phy_rd_en=0, mst_wr_en=0, mst_din=18'h0, pkt_cnt=0, drop_cnt=0, byte counter=0, offset=0, length=0.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame with no abort word pushed.

Verification
REQ-039 Frame to if_macaddr, 10.0.21.199, port 3422, offset 32'h00001000, length 4, data AA BB CC DD -> queue receives 2_0000, 2_1000, 0_AABB, 1_CCDD; pkt_cnt=1.
REQ-040 Same frame with EtherType 16'h0806 -> no queue write; drop_cnt=1; the next valid frame is accepted.
REQ-041 Length 3, then length 1026 -> both dropped with no writes; drop_cnt=2.
REQ-042 Valid header, length 8, gap after 3 data bytes -> queue receives 2 address words, 0_xxxx, 3_0000; drop_cnt=1.
REQ-043 mst_full held high for 10 cycles during DATA -> no pushes and no pops while high; output words are lossless and in order afterwards.
REQ-044 sys_rst_n pulsed low at frame byte 20, with the FIFO still holding the frame tail -> tail discarded in SYNC; the following frame is accepted with pkt_cnt=1.

Source files
------------

// File: rtl/numa_rx_parser_if.sv
// Bus bundle between the RX parser, the RX PHY FIFO and the master write queue.
//   phy_dout  [8]=frame-valid flag (0 = inter-frame gap), [7:0]=byte; valid the
//             cycle after a pop taken while phy_empty was low
//   phy_empty RX PHY FIFO empty
//   phy_rd_en RX PHY FIFO pop
//   mst_din   write-queue word: [17:16]=tag, [15:0]=payload
//   mst_full  write queue full
//   mst_wr_en write-queue push
// The parser takes the master modport; the FIFO/queue side takes the slave modport.
interface numa_rx_parser_if;
    logic [8:0]  phy_dout;
    logic        phy_empty;
    logic        phy_rd_en;
    logic [17:0] mst_din;
    logic        mst_full;
    logic        mst_wr_en;

    modport master (
        input  phy_dout,
        input  phy_empty,
        input  mst_full,
        output phy_rd_en,
        output mst_din,
        output mst_wr_en
    );

    modport slave (
        output phy_dout,
        output phy_empty,
        output mst_full,
        input  phy_rd_en,
        input  mst_din,
        input  mst_wr_en
    );
endinterface

// File: rtl/numa_rx_parser.sv
// Remote-memory write frame parser. Pops bytes from the RX PHY FIFO, filters
// Ethernet/IPv4/UDP headers for the local MAC/IP and the configured UDP port,
// then pushes {tag, payload} words into the master write queue:
// two address words (offset high/low), length/2 data words (last tagged 01),
// or an abort word if the frame is cut short inside the payload.
//   pcie_clk   sole clock, rising edge
//   sys_rst_n  synchronous active-low reset
//   bus        PHY FIFO / write-queue bundle (master modport)
//   if_macaddr local MAC address
//   if_v4addr  local IPv4 address
//   pkt_cnt    accepted frames (wraps)
//   drop_cnt   filtered or aborted frames (wraps)
module numa_rx_parser #(
    parameter logic [15:0] UdpPort = 16'd3422,
    parameter logic [10:0] MaxLen  = 11'd1024
) (
    input  logic                    pcie_clk,
    input  logic                    sys_rst_n,
    numa_rx_parser_if.master        bus,
    input  logic [47:0]             if_macaddr,
    input  logic [31:0]             if_v4addr,
    output logic [15:0]             pkt_cnt,
    output logic [15:0]             drop_cnt
);

    typedef enum logic [2:0] {
        StSync, StIdle, StHdr, StParam, StAddr, StData, StDrop
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] off_q, off_d;
    logic [15:0] len_q, len_d;
    logic [14:0] wleft_q, wleft_d;
    logic [7:0]  hi_q, hi_d;
    logic        odd_q, odd_d;
    logic        idx_q, idx_d;
    logic        mac_ok_q, mac_ok_d;
    logic        bc_ok_q, bc_ok_d;
    logic [8:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        rd_vld_q;
    logic        run_q;
    logic [17:0] din_q, din_d;
    logic        pend_q, pend_d;
    logic [15:0] pkt_q, drop_q;

    logic        wr_en, can_load, load, pkt_inc, drop_inc, bad;
    logic        byte_vld, fv, mac_ok_n, bc_ok_n;
    logic [8:0]  byte_w;
    logic [7:0]  b, mac_b, ip_b;
    logic [17:0] load_word;
    logic [15:0] len_new;
    logic [10:0] cnt_inc;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;
    logic [1:0]  ip_idx;

    // A word sits in din_q while pend_q is set; it leaves on any non-full cycle.
    assign wr_en    = pend_q & ~bus.mst_full;
    assign can_load = ~pend_q | wr_en;

    // run_q and the live reset keep the FIFO untouched during and right after reset.
    assign bus.phy_rd_en = run_q & sys_rst_n & ~bus.phy_empty & ~bus.mst_full & ~wr_en &
                           (state_q != StAddr);
    assign bus.mst_wr_en = wr_en;
    assign bus.mst_din   = din_q;
    assign pkt_cnt       = pkt_q;
    assign drop_cnt      = drop_q;

    // A byte that could not be consumed (in ADDR, or a stalled push in DATA) is
    // parked in hold_q; while it is parked no pop is issued, so no byte is lost.
    assign byte_vld = hold_vld_q | rd_vld_q;
    assign byte_w   = hold_vld_q ? hold_q : bus.phy_dout;
    assign fv       = byte_w[8];
    assign b        = byte_w[7:0];

    assign cnt_inc  = (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;
    assign mac_sh   = if_macaddr << {cnt_q[2:0], 3'b000};
    assign mac_b    = mac_sh[47:40];
    assign ip_idx   = cnt_q[1:0] - 2'd2;  // bytes 30..33 -> 0..3
    assign ip_sh    = if_v4addr << {ip_idx, 3'b000};
    assign ip_b     = ip_sh[31:24];
    assign mac_ok_n = mac_ok_q & (b == mac_b);
    assign bc_ok_n  = bc_ok_q & (b == 8'hff);
    assign len_new  = {len_q[7:0], b};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        len_d      = len_q;
        wleft_d    = wleft_q;
        hi_d       = hi_q;
        odd_d      = odd_q;
        idx_d      = idx_q;
        mac_ok_d   = mac_ok_q;
        bc_ok_d    = bc_ok_q;
        hold_d     = hold_q;
        hold_vld_d = 1'b0;
        load       = 1'b0;
        load_word  = 18'h0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        bad        = 1'b0;

        unique case (state_q)
            StSync: begin
                if (byte_vld && !fv) state_d = StIdle;
            end
            StIdle: begin
                if (byte_vld && fv) begin
                    cnt_d    = 11'd1;
                    mac_ok_d = (b == if_macaddr[47:40]);
                    bc_ok_d  = (b == 8'hff);
                    state_d  = StHdr;
                end
            end
            StHdr: begin
                if (byte_vld) begin
                    if (!fv) begin
                        state_d  = StIdle;
                        drop_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_q <= 11'd5) begin
                            mac_ok_d = mac_ok_n;
                            bc_ok_d  = bc_ok_n;
                        end
                        case (cnt_q)
                            11'd5:  bad = !(mac_ok_n || bc_ok_n);
                            11'd12: bad = (b != 8'h08);
                            11'd13: bad = (b != 8'h00);
                            11'd14: bad = (b != 8'h45);
                            11'd23: bad = (b != 8'h11);
                            11'd30, 11'd31, 11'd32, 11'd33: bad = (b != ip_b);
                            11'd36: bad = (b != UdpPort[15:8]);
                            11'd37: bad = (b != UdpPort[7:0]);
                            default: bad = 1'b0;
                        endcase
                        if (bad) begin
                            state_d  = StDrop;
                            drop_inc = 1'b1;
                        end else if (cnt_q == 11'd41) begin
                            state_d = StParam;
                        end
                    end
                end
            end
            StParam: begin
                if (byte_vld) begin
                    if (!fv) begin
                        state_d  = StIdle;
                        drop_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_q <= 11'd45) off_d = {off_q[23:0], b};
                        else                 len_d = len_new;
                        if (cnt_q == 11'd47) begin
                            if (len_new == 16'd0 || len_new[0] || len_new > {5'd0, MaxLen}) begin
                                state_d  = StDrop;
                                drop_inc = 1'b1;
                            end else begin
                                state_d = StAddr;
                                idx_d   = 1'b0;
                            end
                        end
                    end
                end
            end
            StAddr: begin
                // Only the byte popped alongside byte 47 can land here.
                hold_d     = byte_w;
                hold_vld_d = byte_vld;
                if (can_load) begin
                    load = 1'b1;
                    if (!idx_q) begin
                        load_word = {2'b10, off_q[31:16]};
                        idx_d     = 1'b1;
                    end else begin
                        load_word = {2'b10, off_q[15:0]};
                        wleft_d   = len_q[15:1];
                        odd_d     = 1'b0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (byte_vld) begin
                    if (!fv) begin
                        if (can_load) begin
                            load      = 1'b1;
                            load_word = {2'b11, 16'h0000};
                            drop_inc  = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            hold_d     = byte_w;
                            hold_vld_d = 1'b1;
                        end
                    end else if (!odd_q) begin
                        cnt_d = cnt_inc;
                        hi_d  = b;
                        odd_d = 1'b1;
                    end else if (can_load) begin
                        cnt_d     = cnt_inc;
                        load      = 1'b1;
                        load_word = {(wleft_q == 15'd1) ? 2'b01 : 2'b00, hi_q, b};
                        odd_d     = 1'b0;
                        wleft_d   = wleft_q - 15'd1;
                        if (wleft_q == 15'd1) begin
                            pkt_inc = 1'b1;
                            state_d = StDrop;
                        end
                    end else begin
                        hold_d     = byte_w;
                        hold_vld_d = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (byte_vld) begin
                    if (!fv) state_d = StIdle;
                    else     cnt_d   = cnt_inc;
                end
            end
            default: state_d = StSync;
        endcase

        din_d  = load ? load_word : din_q;
        pend_d = load | (pend_q & ~wr_en);
    end

    always_ff @(posedge pcie_clk) begin
        if (!sys_rst_n) begin
            state_q    <= StSync;
            cnt_q      <= 11'd0;
            off_q      <= 32'd0;
            len_q      <= 16'd0;
            wleft_q    <= 15'd0;
            hi_q       <= 8'd0;
            odd_q      <= 1'b0;
            idx_q      <= 1'b0;
            mac_ok_q   <= 1'b0;
            bc_ok_q    <= 1'b0;
            hold_q     <= 9'd0;
            hold_vld_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            run_q      <= 1'b0;
            din_q      <= 18'h0;
            pend_q     <= 1'b0;
            pkt_q      <= 16'd0;
            drop_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            len_q      <= len_d;
            wleft_q    <= wleft_d;
            hi_q       <= hi_d;
            odd_q      <= odd_d;
            idx_q      <= idx_d;
            mac_ok_q   <= mac_ok_d;
            bc_ok_q    <= bc_ok_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            rd_vld_q   <= bus.phy_rd_en;
            run_q      <= 1'b1;
            din_q      <= din_d;
            pend_q     <= pend_d;
            pkt_q      <= pkt_q + {15'd0, pkt_inc};
            drop_q     <= drop_q + {15'd0, drop_inc};
        end
    end

endmodule
